// File: rtl/dot_product_engine_pkg.sv
// Shared constants and types for the dot-product calculation stage and
// the Avalon slave that feeds it.
package nn_calc_pkg;
    localparam int N_WORDS = 392;
    localparam int N_OUT   = 10;
    localparam int ACC_W   = 40;
    localparam int FRAC    = 15;
    localparam int RES_W   = 17;
    localparam int PROD_W  = 33;
    localparam int PADDR_W = 10;
    localparam int WADDR_W = 12;

    localparam int signed RES_MAX = 65535;
    localparam int signed RES_MIN = -65536;

    typedef logic [3:0] res_addr_t;

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, STORE, DONE} state_t;
endpackage

// File: rtl/dot_product_engine_if.sv
// Bundle between the Avalon slave (master side: memories, control, readback)
// and the dot-product engine (slave side).
interface dot_product_engine_if;
    import nn_calc_pkg::*;

    logic                start_calc;
    logic                clear_data;
    logic [PADDR_W-1:0]  pixel_address1;
    logic [PADDR_W-1:0]  pixel_address2;
    logic [15:0]         pixel_data1;
    logic [15:0]         pixel_data2;
    logic [WADDR_W-1:0]  weight_address;
    logic [31:0]         weight_data;
    res_addr_t           output_address;
    logic [RES_W-1:0]    result_output;
    logic                done_calc;
    logic                overflow;
    logic                busy;

    modport master (
        output start_calc, clear_data, pixel_data1, pixel_data2, weight_data, output_address,
        input  pixel_address1, pixel_address2, weight_address, result_output,
               done_calc, overflow, busy
    );

    modport slave (
        input  start_calc, clear_data, pixel_data1, pixel_data2, weight_data, output_address,
        output pixel_address1, pixel_address2, weight_address, result_output,
               done_calc, overflow, busy
    );
endinterface

// File: rtl/dot_product_engine_mac_unit.sv
// Two-stage multiply/accumulate: registered pixel*weight products for both
// pixels of a word, then a signed 40-bit accumulate.
module mac_unit
    import nn_calc_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic [15:0]             pix0,
    input  logic [15:0]             pix1,
    input  logic [31:0]             wgt,
    output logic signed [ACC_W-1:0] acc
);
    // [0]: memory data returning this cycle, [1]: products valid this cycle
    logic [1:0]               vld_pipe_q, vld_pipe_d;
    logic signed [PROD_W-1:0] p0_q, p0_d, p1_q, p1_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;

    always_comb begin
        vld_pipe_d = {vld_pipe_q[0], en};
        p0_d       = p0_q;
        p1_d       = p1_q;
        acc_d      = acc_q;
        if (vld_pipe_q[0]) begin
            p0_d = $signed({17'd0, pix0}) * $signed({{17{wgt[15]}}, wgt[15:0]});
            p1_d = $signed({17'd0, pix1}) * $signed({{17{wgt[31]}}, wgt[31:16]});
        end
        if (vld_pipe_q[1])
            acc_d = acc_q + {{(ACC_W-PROD_W){p0_q[PROD_W-1]}}, p0_q}
                          + {{(ACC_W-PROD_W){p1_q[PROD_W-1]}}, p1_q};
        if (clr) begin
            vld_pipe_d = '0;
            acc_d      = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
            p0_q       <= '0;
            p1_q       <= '0;
            acc_q      <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            p0_q       <= p0_d;
            p1_q       <= p1_d;
            acc_q      <= acc_d;
        end
    end

    assign acc = acc_q;
endmodule

// File: rtl/dot_product_engine.sv
// Sequences pixel/weight memory reads for each output neuron, accumulates the
// dot product, and stores the Q-scaled, saturated result per neuron.
module dot_product_engine
    import nn_calc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    dot_product_engine_if.slave bus
);
    localparam logic [PADDR_W-1:0]       K_LAST = PADDR_W'(N_WORDS - 1);
    localparam res_addr_t                N_LAST = 4'(N_OUT - 1);
    localparam logic signed [ACC_W-1:0]  SH_MAX = ACC_W'(RES_MAX);
    localparam logic signed [ACC_W-1:0]  SH_MIN = ACC_W'(RES_MIN);

    state_t              state_q, state_d;
    logic [PADDR_W-1:0]  k_q, k_d;
    res_addr_t           n_q, n_d;
    logic [WADDR_W-1:0]  waddr_q, waddr_d;
    logic                drain_q, drain_d;
    logic                ovf_q, ovf_d;
    logic [RES_W-1:0]    res_q [N_OUT];
    logic [RES_W-1:0]    res_d [N_OUT];

    logic                    mac_clr, mac_en;
    logic signed [ACC_W-1:0] acc, sh;
    logic [RES_W-1:0]        sat_val;
    logic                    sat_hit;

    mac_unit u_mac (
        .clk  (clk),
        .rst  (rst),
        .clr  (mac_clr),
        .en   (mac_en),
        .pix0 (bus.pixel_data1),
        .pix1 (bus.pixel_data2),
        .wgt  (bus.weight_data),
        .acc  (acc)
    );

    always_comb begin
        sh      = acc >>> FRAC;
        sat_hit = 1'b1;
        if (sh > SH_MAX)
            sat_val = RES_W'(RES_MAX);
        else if (sh < SH_MIN)
            sat_val = RES_W'(RES_MIN);
        else begin
            sat_val = sh[RES_W-1:0];
            sat_hit = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        waddr_d = waddr_q;
        drain_d = drain_q;
        ovf_d   = ovf_q;
        res_d   = res_q;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start_calc) begin
                    state_d = RUN;
                    k_d     = '0;
                    n_d     = '0;
                    waddr_d = '0;
                    ovf_d   = 1'b0;
                    mac_clr = 1'b1;
                end
            end
            RUN: begin
                mac_en = 1'b1;
                if (k_q == K_LAST) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end else begin
                    k_d     = k_q + PADDR_W'(1);
                    waddr_d = waddr_q + WADDR_W'(1);
                end
            end
            DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) state_d = STORE;
            end
            STORE: begin
                res_d[n_q] = sat_val;
                if (sat_hit) ovf_d = 1'b1;
                mac_clr = 1'b1;
                if (n_q == N_LAST) begin
                    state_d = DONE;
                end else begin
                    // weight rows are contiguous, so the next row starts one past this one
                    state_d = RUN;
                    n_d     = n_q + 4'd1;
                    k_d     = '0;
                    waddr_d = waddr_q + WADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.clear_data) begin
            state_d = IDLE;
            k_d     = '0;
            n_d     = '0;
            waddr_d = '0;
            drain_d = 1'b0;
            ovf_d   = 1'b0;
            mac_clr = 1'b1;
            for (int i = 0; i < N_OUT; i++) res_d[i] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            n_q     <= '0;
            waddr_q <= '0;
            drain_q <= 1'b0;
            ovf_q   <= 1'b0;
            res_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            waddr_q <= waddr_d;
            drain_q <= drain_d;
            ovf_q   <= ovf_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        bus.result_output = '0;
        for (int i = 0; i < N_OUT; i++)
            if (bus.output_address == 4'(i)) bus.result_output = res_q[i];
    end

    assign bus.pixel_address1 = k_q;
    assign bus.pixel_address2 = k_q;
    assign bus.weight_address = waddr_q;
    assign bus.done_calc      = (state_q == DONE);
    assign bus.overflow       = ovf_q;
    assign bus.busy           = (state_q == RUN) || (state_q == DRAIN) || (state_q == STORE);
endmodule

// File: tb/tb_dot_product_engine.sv
// Bench for dot_product_engine: external memories, a timeline model of the
// calculation, and directed scenarios with hand-computed results.
module tb_dot_product_engine;
    import nn_calc_pkg::*;

    localparam int PER_N = N_WORDS + 3;
    localparam int TOTAL = N_OUT * PER_N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dot_product_engine_if bus();
    dot_product_engine dut (.clk(clk), .rst(rst), .bus(bus));

    logic [15:0] pix1 [N_WORDS];
    logic [15:0] pix2 [N_WORDS];
    logic [31:0] wmem [N_OUT*N_WORDS];

    int checks = 0;
    int errors = 0;

    // synchronous-read memories, one cycle latency
    always @(posedge clk) begin
        bus.pixel_data1 <= (int'(bus.pixel_address1) < N_WORDS) ? pix1[bus.pixel_address1] : 16'h0;
        bus.pixel_data2 <= (int'(bus.pixel_address2) < N_WORDS) ? pix2[bus.pixel_address2] : 16'h0;
        bus.weight_data <= (int'(bus.weight_address) < N_OUT*N_WORDS) ? wmem[bus.weight_address] : 32'h0;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic                    m_run, m_done, m_ovf;
    int                      m_cnt;
    logic signed [RES_W-1:0] m_res [N_OUT];

    function automatic longint neuron_raw(input int n);
        longint s = 0;
        for (int k = 0; k < N_WORDS; k++) begin
            s += longint'(pix1[k]) * longint'($signed(wmem[n*N_WORDS+k][15:0]));
            s += longint'(pix2[k]) * longint'($signed(wmem[n*N_WORDS+k][31:16]));
        end
        return s >>> FRAC;
    endfunction

    always @(posedge clk or posedge rst) begin
        longint r;
        if (rst) begin
            m_run = 0; m_done = 0; m_ovf = 0; m_cnt = 0;
            for (int i = 0; i < N_OUT; i++) m_res[i] = '0;
        end else if (bus.clear_data) begin
            m_run = 0; m_done = 0; m_ovf = 0;
            for (int i = 0; i < N_OUT; i++) m_res[i] = '0;
        end else if (m_run) begin
            m_cnt++;
            if (m_cnt % PER_N == 0) begin
                r = neuron_raw(m_cnt / PER_N - 1);
                if (r > RES_MAX) begin r = RES_MAX; m_ovf = 1; end
                if (r < RES_MIN) begin r = RES_MIN; m_ovf = 1; end
                m_res[m_cnt / PER_N - 1] = RES_W'(r);
            end
            if (m_cnt == TOTAL) begin m_run = 0; m_done = 1; end
        end else if (bus.start_calc) begin
            m_run = 1; m_cnt = 0; m_done = 0; m_ovf = 0;
        end
    end

    function automatic logic signed [RES_W-1:0] exp_res(input logic [3:0] a);
        if (int'(a) < N_OUT) return m_res[a];
        return '0;
    endfunction

    always @(negedge clk) begin
        chk("busy", bus.busy, m_run);
        chk("done_calc", bus.done_calc, m_done);
        chk("overflow", bus.overflow, m_ovf);
        chk("result_output", $signed(bus.result_output), exp_res(bus.output_address));
        if (m_run && (m_cnt % PER_N) < N_WORDS) begin
            chk("weight_address", bus.weight_address, (m_cnt / PER_N) * N_WORDS + m_cnt % PER_N);
            chk("pixel_address1", bus.pixel_address1, m_cnt % PER_N);
            chk("pixel_address2", bus.pixel_address2, m_cnt % PER_N);
        end
    end

    // ---------------- stimulus ----------------
    task automatic fill(input bit ramp, input logic [15:0] p, input logic [31:0] w_even,
                        input logic [31:0] w_odd);
        for (int k = 0; k < N_WORDS; k++) begin
            pix1[k] = ramp ? 16'(k) : p;
            pix2[k] = ramp ? 16'(k) : p;
        end
        for (int n = 0; n < N_OUT; n++)
            for (int k = 0; k < N_WORDS; k++)
                wmem[n*N_WORDS+k] = (n % 2 == 0) ? w_even : w_odd;
    endtask

    task automatic read_res(input int a, output longint v);
        @(posedge clk); #2;
        bus.output_address = 4'(a);
        #1 v = $signed(bus.result_output);
    endtask

    // done_cyc counts edges after the one that samples start; -1 if done never rose
    task automatic run_calc(input int poke_at, input bit poke_clear, input bit poke_start,
                            output int done_cyc);
        @(posedge clk); #2 bus.start_calc = 1'b1;
        @(posedge clk); #2 bus.start_calc = 1'b0;
        done_cyc = -1;
        for (int i = 1; i <= TOTAL + 150; i++) begin
            @(posedge clk); #2;
            bus.output_address = bus.output_address + 4'd1;
            bus.clear_data = (i == poke_at) ? poke_clear : 1'b0;
            bus.start_calc = (i == poke_at) ? poke_start : 1'b0;
            if (bus.done_calc) begin done_cyc = i; break; end
            if (poke_clear && i == poke_at + 1) break;
        end
    endtask

    initial begin
        int     dc;
        longint v;
        bus.start_calc = 1'b0;
        bus.clear_data = 1'b0;
        bus.output_address = '0;
        fill(1'b0, 16'h0010, 32'h4000_4000, 32'h4000_4000);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done_calc, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_waddr", bus.weight_address, 0);
        chk("rst_paddr", bus.pixel_address1, 0);
        chk("rst_result", bus.result_output, 0);
        @(posedge clk); #2 rst = 1'b0;

        // uniform positive
        run_calc(0, 1'b0, 1'b0, dc);
        chk("uniform_done_cycle", dc, 3950);
        read_res(0, v); chk("uniform_r0", v, 6272);
        read_res(9, v); chk("uniform_r9", v, 6272);
        chk("uniform_ovf", bus.overflow, 0);

        // signed rows
        fill(1'b0, 16'h0010, 32'h4000_4000, 32'hC000_C000);
        run_calc(0, 1'b0, 1'b0, dc);
        chk("signed_done_cycle", dc, 3950);
        read_res(2, v); chk("signed_r2", v, 6272);
        read_res(3, v); chk("signed_r3", v, -6272);
        chk("signed_r3_bits", longint'(bus.result_output), 17'h1E780);
        read_res(12, v); chk("addr12_zero", v, 0);

        // positive / negative saturation
        fill(1'b0, 16'h0100, 32'h4000_4000, 32'h4000_4000);
        run_calc(0, 1'b0, 1'b0, dc);
        read_res(5, v); chk("satpos_r5", v, 65535);
        chk("satpos_ovf", bus.overflow, 1);
        fill(1'b0, 16'h0100, 32'hC000_C000, 32'hC000_C000);
        run_calc(0, 1'b0, 1'b0, dc);
        read_res(4, v); chk("satneg_r4", v, -65536);
        chk("satneg_ovf", bus.overflow, 1);

        // addressing: ramp pixels, -1.0 on the low half only
        fill(1'b1, 16'h0, 32'h0000_8000, 32'h0000_8000);
        run_calc(0, 1'b0, 1'b0, dc);
        chk("addr_done_cycle", dc, 3950);
        read_res(7, v); chk("addr_r7", v, -65536);
        chk("addr_ovf", bus.overflow, 1);

        // start pulsed mid-run is ignored
        fill(1'b0, 16'h0010, 32'h4000_4000, 32'h4000_4000);
        run_calc(1000, 1'b0, 1'b1, dc);
        chk("restart_ignored_done_cycle", dc, 3950);
        read_res(1, v); chk("restart_r1", v, 6272);

        // async reset mid-run
        @(posedge clk); #2 bus.start_calc = 1'b1;
        @(posedge clk); #2 bus.start_calc = 1'b0;
        repeat (500) @(posedge clk);
        #1 bus.output_address = 4'd0;
        rst = 1'b1;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_waddr", bus.weight_address, 0);
        chk("midrst_paddr", bus.pixel_address2, 0);
        chk("midrst_r0", bus.result_output, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // abort then normal rerun
        run_calc(1000, 1'b1, 1'b0, dc);
        chk("abort_no_done", dc, -1);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done_calc, 0);
        read_res(0, v); chk("abort_r0_cleared", v, 0);
        run_calc(0, 1'b0, 1'b0, dc);
        chk("rerun_done_cycle", dc, 3950);
        read_res(8, v); chk("rerun_r8", v, 6272);

        // start and clear together: clear wins
        @(posedge clk); #2;
        bus.start_calc = 1'b1;
        bus.clear_data = 1'b1;
        @(posedge clk); #2;
        bus.start_calc = 1'b0;
        bus.clear_data = 1'b0;
        chk("startclr_busy", bus.busy, 0);
        chk("startclr_done", bus.done_calc, 0);
        repeat (3) @(posedge clk);
        #2 chk("startclr_still_idle", bus.busy, 0);
        read_res(8, v); chk("startclr_r8", v, 0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dot_product_engine.md
Name: dot_product_engine

Overview:
- Calculation stage directly downstream of the Avalon slave interface. The slave fills the pixel and weight memories, then pulses start_calc.
- This block reads both memories and computes N_OUT signed dot products of the 784-pixel image against each output neuron's weight row.
- It holds the saturated results in a register file that the slave reads through output_address / result_output.
- It reports completion (done_calc) and saturation (overflow) back to the slave's status register.

Parameters:
N_WORDS, 392, 32-bit pixel words per image (two 16-bit pixels per word)
N_OUT, 10, output neurons / result registers
ACC_W, 40, accumulator width (signed)
FRAC, 15, weight fractional bits (weights are Q1.15)
RES_W, 17, result width (signed)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start_calc  in  1  begin calculation (level sampled on the rising edge)
clear_data  in  1  synchronous abort/clear
pixel_address1  out  10  word index k into pixel bank 1 (pixel 2k)
pixel_address2  out  10  word index k into pixel bank 2 (pixel 2k+1)
pixel_data1  in  16  unsigned pixel 2k, valid 1 cycle after address
pixel_data2  in  16  unsigned pixel 2k+1, valid 1 cycle after address
weight_address  out  12  n*N_WORDS + k
weight_data  in  32  [15:0] = signed weight for pixel 2k, [31:16] = signed weight for pixel 2k+1; valid 1 cycle after address
output_address  in  4  result register select
result_output  out  17  result[output_address], combinational; 0 if output_address >= N_OUT
done_calc  out  1  calculation complete
overflow  out  1  sticky saturation flag
busy  out  1  high in RUN/DRAIN/STORE

Behaviour:
- Reset (async): state IDLE; k = 0; n = 0; acc = 0; all results 0; done_calc = 0; overflow = 0; busy = 0; all address outputs 0.
- The memories are external, synchronous-read, with 1-cycle latency.
- IDLE or DONE, with start_calc = 1 and clear_data = 0:
  - Next state RUN; k = 0, n = 0, acc = 0.
  - done_calc and overflow clear; results retain their old values until overwritten.
- RUN, one word per cycle:
  - Drive pixel_address1 = pixel_address2 = k and weight_address = n*N_WORDS + k.
  - k increments; after k = N_WORDS-1, go to DRAIN.
- Pipeline:
  - Stage 1 (data return): p0 = pixel_data1 * $signed(weight_data[15:0]) and p1 = pixel_data2 * $signed(weight_data[31:16]). Pixels are zero-extended; products are 33-bit signed; the stage is registered.
  - Stage 2: acc += sext(p0) + sext(p1).
- DRAIN: 2 cycles, flushing the pipeline. Then go to STORE.
- STORE, one cycle:
  - r = acc >>> FRAC (arithmetic shift).
  - Saturate r to [-65536, 65535]; on saturation set overflow (sticky).
  - Write result[n]; clear acc.
  - If n = N_OUT-1, go to DONE; otherwise n++, k = 0, back to RUN.
- Per-neuron cost is N_WORDS+3 cycles. done_calc rises exactly N_OUT*(N_WORDS+3) = 3950 cycles after the edge that samples start_calc.
- DONE: done_calc = 1 and is held until clear_data or a new start_calc.
- start_calc while busy: ignored.
- clear_data:
  - Highest priority in any state.
  - Next cycle: IDLE, all results 0, done_calc = 0, overflow = 0, acc = 0, k = n = 0.
  - Mid-run, it aborts the run with no partial result written.
- start_calc and clear_data both high: clear wins; start is not latched.
- Address outputs hold their last value outside RUN; memory contents are never written by this block.
- No wrap: k is bounded at N_WORDS-1, n at N_OUT-1.

Decomposition:
- Package nn_calc_pkg holds:
  - N_WORDS, N_OUT, ACC_W, FRAC, RES_W
  - RES_MAX = 65535, RES_MIN = -65536
  - state_t enum {IDLE, RUN, DRAIN, STORE, DONE}
  - the 4-bit result-address type, shared with the slave interface
- Sub-module mac_unit: the two-stage multiply/accumulate with clr and en inputs, producing the 40-bit acc. Counters, FSM, saturation and the result file stay in the top level.

Test Plan:
- Uniform positive: all pixels 0x0010; all weights 0x4000 (0.5) → after start, done_calc rises at cycle 3950. Every result = 6272; overflow = 0.
- Signed rows: weights 0x4000 for even n, 0xC000 for odd n; pixels 0x0010 → result[even] = 6272, result[odd] = -6272 (17'h1E780); output_address = 12 reads 0.
- Saturation: pixels 0x0100, weights 0x4000 → every result = 65535, overflow = 1. Repeat with weights 0xC000 → every result = -65536, overflow = 1.
- Addressing: pixels = index k in both banks; weight word n*392 + k = {16'h0000, 16'h8000} (low half = -1.0) → result[n] = -(0+1+…+391) = -76636, saturated to -65536. Also check weight_address sequence 0..3919 contiguous, one address per RUN cycle.
- Abort: clear_data at cycle 1000 of a run → next cycle busy = 0, all results 0, done_calc stays 0. A new start then completes normally in 3950 cycles.
- Control edges:
  - start_calc pulsed again mid-run → ignored; done still arrives at cycle 3950.
  - start + clear high together → stays IDLE.
  - rst asserted mid-run → outputs zero immediately, without waiting for a clock edge.
